// File: rtl/syn_fifo_pkg.sv
// Shared constants for the single-clock FIFO: default geometry and the
// address-width helper used by the top and the pointer counters.
package syn_fifo_pkg;

  localparam int FIFO_ENTRIES_DEF = 16;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int ADDR_W           = $clog2(FIFO_ENTRIES_DEF);

  // Address width for an arbitrary power-of-two depth.
  function automatic int addr_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/syn_fifo_ptr.sv
// Free-running FIFO pointer with one extra wrap bit above the address bits;
// the wrap bit lets full and empty be told apart when the addresses match.
module syn_fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [AW:0] ptr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/syn_fifo.sv
// Single-clock synchronous FIFO with registered read data and an output enable.
// Storage is exposed as mem_array so entries can be inspected hierarchically.
module syn_fifo
  import syn_fifo_pkg::*;
#(
  parameter int FIFO_ENTRIES = FIFO_ENTRIES_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  localparam int AW          = addr_w(FIFO_ENTRIES)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  rd_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic [AW-1:0]         w_index,
  output logic [AW-1:0]         r_index
);

  logic [DATA_WIDTH-1:0] mem_array [0:FIFO_ENTRIES-1];

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        wr_acc;
  logic        rd_acc;

  // Both sides are qualified by the flags as they stand before the edge, so a
  // full FIFO only reads and an empty FIFO only writes; there is no bypass.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  syn_fifo_ptr #(.AW(AW)) u_wptr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .inc   (wr_acc),
    .ptr   (wptr)
  );

  syn_fifo_ptr #(.AW(AW)) u_rptr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .inc   (rd_acc),
    .ptr   (rptr)
  );

  assign w_index = wptr[AW-1:0];
  assign r_index = rptr[AW-1:0];
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count   = wptr - rptr;

  // NOTE: the storage array has no reset; after reset the pointers alone make
  // its old contents unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge sys_clk) begin
    if (wr_acc)
      mem_array[w_index] <= data_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      data_out <= '0;
    else if (rd_acc && rd_oe)
      data_out <= mem_array[r_index];
  end

endmodule

// File: tb/tb_syn_fifo.sv
// Randomized self-checking bench for syn_fifo against a queue-based model.
module tb_syn_fifo;
  import syn_fifo_pkg::*;

  localparam int N  = FIFO_ENTRIES_DEF;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int AW = $clog2(N);

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          wr_en;
  logic          rd_en;
  logic          rd_oe;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [AW-1:0] w_index;
  logic [AW-1:0] r_index;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: occupancy is a queue, indices are plain modulo counters.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_mem [N];
  int            exp_w;
  int            exp_r;
  logic [DW-1:0] exp_dout;

  syn_fifo #(.FIFO_ENTRIES(N), .DATA_WIDTH(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .rd_oe     (rd_oe),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .w_index   (w_index),
    .r_index   (r_index)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_w    = 0;
    exp_r    = 0;
    exp_dout = '0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    check($sformatf("%s.count", tag),    32'(count),    32'(sz));
    check($sformatf("%s.empty", tag),    32'(empty),    32'(sz == 0));
    check($sformatf("%s.full", tag),     32'(full),     32'(sz == N));
    check($sformatf("%s.w_index", tag),  32'(w_index),  32'(exp_w));
    check($sformatf("%s.r_index", tag),  32'(r_index),  32'(exp_r));
    check($sformatf("%s.data_out", tag), 32'(data_out), 32'(exp_dout));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s.mem[%0d]", tag, i), 32'(dut.mem_array[i]), 32'(exp_mem[i]));
  endtask

  // Called at a falling edge: drive, advance one rising edge, update model, check.
  task automatic cycle(input string tag, input logic we, input logic [DW-1:0] din,
                       input logic re, input logic oe);
    bit            acc_w;
    bit            acc_r;
    logic [DW-1:0] d;
    wr_en   = we;
    data_in = din;
    rd_en   = re;
    rd_oe   = oe;
    acc_w = we && (model_q.size() < N);
    acc_r = re && (model_q.size() > 0);
    @(posedge sys_clk);
    if (acc_r) begin
      d = model_q.pop_front();
      if (oe) exp_dout = d;
      exp_r = (exp_r + 1) % N;
    end
    if (acc_w) begin
      model_q.push_back(din);
      exp_mem[exp_w] = din;
      exp_w = (exp_w + 1) % N;
    end
    @(negedge sys_clk);
    check_state(tag);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    model_reset();
    check_state("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_oe     = 1'b0;
    data_in   = '0;
    sys_rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) exp_mem[i] = '0;

    @(negedge sys_clk);
    @(negedge sys_clk);
    check_state("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_state("post_reset");

    // Interrupted write: 8 writes, 8 idle cycles, 8 writes.
    for (int i = 0; i < 8; i++) cycle("wr_a", 1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("wr_gap", 1'b0, DW'($urandom), 1'b0, 1'b0);
    check("wr_gap.hold_idx", 32'(w_index), 32'(8));
    for (int i = 0; i < 8; i++) cycle("wr_b", 1'b1, DW'($urandom), 1'b0, 1'b0);
    check("wr_done.full", 32'(full), 32'(1));
    check("wr_done.count", 32'(count), 32'(N));
    check("wr_done.w_wrap", 32'(w_index), 32'(0));
    check_mem("wr_done");

    // Overflow: write while full must change nothing.
    cycle("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    check_mem("ovf");

    // Interrupted read of the full FIFO.
    for (int i = 0; i < 8; i++) cycle("rd_a", 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle("rd_gap", 1'b0, '0, 1'b0, 1'b1);
    check("rd_gap.hold_idx", 32'(r_index), 32'(8));
    for (int i = 0; i < 8; i++) cycle("rd_b", 1'b0, '0, 1'b1, 1'b1);
    check("rd_done.empty", 32'(empty), 32'(1));
    check("rd_done.last", 32'(data_out), 32'(exp_mem[N-1]));

    // Underflow: read while empty holds pointer and data.
    cycle("udf", 1'b0, '0, 1'b1, 1'b1);

    // Simultaneous read/write at count=5.
    do_reset();
    for (int i = 0; i < 5; i++) cycle("fill5", 1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle("rw5", 1'b1, DW'($urandom), 1'b1, 1'b1);
    check("rw5.count", 32'(count), 32'(5));

    // Simultaneous read/write at full: only the read happens.
    for (int i = 0; i < 11; i++) cycle("fill16", 1'b1, DW'($urandom), 1'b0, 1'b0);
    check("fill16.full", 32'(full), 32'(1));
    cycle("rw16", 1'b1, DW'($urandom), 1'b1, 1'b1);
    check("rw16.count", 32'(count), 32'(N-1));

    // Read with rd_oe=0 advances the pointer but holds data_out.
    cycle("noe", 1'b0, '0, 1'b1, 1'b0);

    // Reset asserted mid-cycle clears state without waiting for a clock edge.
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.count", 32'(count), 32'(0));
    check("async_rst.empty", 32'(empty), 32'(1));
    check("async_rst.dout", 32'(data_out), 32'(0));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_state("after_async_rst");

    // Random traffic: write-heavy, then read-heavy, to visit full and empty.
    for (int i = 0; i < 300; i++)
      cycle("rand_w", 1'b1 && ($urandom_range(3) != 0), DW'($urandom),
            ($urandom_range(3) == 0), ($urandom_range(3) != 0));
    for (int i = 0; i < 300; i++)
      cycle("rand_r", ($urandom_range(3) == 0), DW'($urandom),
            ($urandom_range(3) != 0), ($urandom_range(3) != 0));
    for (int i = 0; i < 300; i++)
      cycle("rand_mix", 1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_fifo.md
Name: syn_fifo

Overview:
Single-clock synchronous FIFO, FIFO_ENTRIES deep by DATA_WIDTH wide. It is used as a general buffering element between a producer and a consumer in the same clock domain. It exposes its write/read indices and its storage array (mem_array) so that the test environment can check individual entries.

Parameters:
FIFO_ENTRIES, 16, number of storage entries; must be a power of two and at least 2.
DATA_WIDTH, 8, bit width of each entry.

Ports:
sys_clk  input  1  single clock; all state updates on the rising edge.
sys_rst_n  input  1  asynchronous, active-low reset.
wr_en  input  1  write request; accepted on a rising edge when full=0.
data_in  input  DATA_WIDTH  write data.
rd_en  input  1  read request; accepted on a rising edge when empty=0.
rd_oe  input  1  output enable for data_out.
data_out  output  DATA_WIDTH  registered read data.
full  output  1  FIFO holds FIFO_ENTRIES entries.
empty  output  1  FIFO holds 0 entries.
count  output  $clog2(FIFO_ENTRIES)+1  current occupancy.
w_index  output  $clog2(FIFO_ENTRIES)  current write address (next slot to write).
r_index  output  $clog2(FIFO_ENTRIES)  current read address (next slot to read).

Behaviour:
- Reset (sys_rst_n=0, asynchronous): write and read pointers = 0, count = 0, empty = 1, full = 0, data_out = 0. mem_array is not reset.
- Storage is an internal array named mem_array[0:FIFO_ENTRIES-1] of DATA_WIDTH bits. It must remain hierarchically accessible under that name in this module.
- Pointers are $clog2(FIFO_ENTRIES)+1 bits wide; the extra MSB is a wrap bit. w_index and r_index are the pointer LSBs.
- Full and empty are decoded combinationally from the pointers:
  - empty = (wptr == rptr).
  - full = (LSBs equal AND MSBs differ).
  - count = wptr - rptr, computed modulo 2^(ADDR+1).
- Write: on a rising edge with wr_en=1 and full=0:
  - mem_array[w_index] <= data_in.
  - wptr increments by 1 and wraps naturally.
  - wr_en=0 leaves memory and wptr unchanged, for any number of cycles; a later write resumes at the held index.
- Read: on a rising edge with rd_en=1 and empty=0:
  - data_out <= mem_array[r_index] when rd_oe=1.
  - rptr increments by 1.
  - Read latency is 1 cycle: data is valid after the accepting edge.
- rd_en=0 or empty=1: rptr unchanged and data_out holds its value.
- rd_oe=0: data_out holds its value even when a read is accepted; the pointer still advances.
- Write when full is ignored: no memory write, no pointer change, no error flag.
- Read when empty is ignored: pointer unchanged, data_out held.
- Simultaneous wr_en and rd_en:
  - Each side is qualified by the flag values before the edge.
  - When neither full nor empty, both occur and count is unchanged.
  - When full, only the read occurs. When empty, only the write occurs. There is no write-through bypass.
- Wrap-around: after index FIFO_ENTRIES-1 the pointer LSBs return to 0 and the MSB toggles.
- Reset asserted mid-operation: pointers and flags clear immediately; any data held in memory is logically discarded.

Decomposition:
- Package syn_fifo_pkg holds:
  - default constants FIFO_ENTRIES_DEF=16 and DATA_WIDTH_DEF=8;
  - a helper localparam ADDR_W = $clog2(FIFO_ENTRIES).
- An optional sub-module syn_fifo_ptr holds one pointer counter with wrap bit; instantiate it twice (write and read).
- mem_array stays in the top-level syn_fifo.

Test Plan:
- Reset -> empty=1, full=0, count=0, w_index=0, r_index=0, data_out=0.
- Interrupted write:
  - Write 8 random bytes with wr_en=1, then 8 cycles with wr_en=0, then 8 more writes.
  - Required: w_index steps 0..7, holds at 8 during the gap, then steps 8..15; wraps to 0 after the last write.
  - mem_array[0..15] equals the 16 accepted bytes in order; full=1, count=16.
- Interrupted read on the full FIFO:
  - 8 reads, then 8 cycles with rd_en=0, then 8 reads.
  - Required: data_out sequence equals mem_array[0..15]; r_index holds at 8 during the gap; finally empty=1, count=0.
- Overflow: 17th write when full (data 0xAA) -> mem_array unchanged, w_index unchanged, full stays 1.
- Underflow: rd_en=1 while empty -> r_index unchanged, data_out holds its last value.
- Simultaneous read/write at count=5 -> count stays 5 and both indices advance by 1. At count=16, only the read takes effect.
